// File: rtl/intc_pkg.sv
// intc_pkg: shared constants for the machine-level interrupt source.
//   - Byte offsets of the memory-mapped registers (5-bit bus address space).
//   - Cause codes driven on irq_code, claim "none" id, mtimecmp reset value.
package intc_pkg;

  localparam logic [4:0] ADDR_MSIP        = 5'h00;
  localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] ADDR_MTIME_LO    = 5'h0C;
  localparam logic [4:0] ADDR_MTIME_HI    = 5'h10;
  localparam logic [4:0] ADDR_EXT_PENDING = 5'h14;
  localparam logic [4:0] ADDR_EXT_ENABLE  = 5'h18;
  localparam logic [4:0] ADDR_CLAIM       = 5'h1C;

  typedef enum logic [3:0] {
    CAUSE_NONE = 4'd0,
    CAUSE_MSI  = 4'd3,
    CAUSE_MTI  = 4'd7,
    CAUSE_MEI  = 4'd11
  } cause_e;

  localparam logic [31:0] CLAIM_NONE   = 32'd0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/intc_timer.sv
// intc_timer: prescaled 64-bit mtime counter, mtimecmp register and comparator.
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_wr_cmp_lo/hi        write strobes for the mtimecmp halves
//   i_wr_time_lo/hi       write strobes for the mtime halves
//   i_wdata               bus write data
//   o_mtime, o_mtimecmp   current register values (for bus reads)
//   o_mtip                mtime >= mtimecmp (unsigned, combinational)
module intc_timer
  import intc_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_cmp_lo,
  input  logic        i_wr_cmp_hi,
  input  logic        i_wr_time_lo,
  input  logic        i_wr_time_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_mtip
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          w_tick;
  logic [63:0]   w_mtime_inc;

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_mtime_inc = r_mtime + 64'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= MTIMECMP_RST;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      // A bus write beats the tick; the other half is left untouched that cycle.
      if (i_wr_time_lo) begin
        r_mtime[31:0] <= i_wdata;
      end else if (i_wr_time_hi) begin
        r_mtime[63:32] <= i_wdata;
      end else if (w_tick) begin
        r_mtime <= w_mtime_inc;
      end
      if (i_wr_cmp_lo) r_mtimecmp[31:0]  <= i_wdata;
      if (i_wr_cmp_hi) r_mtimecmp[63:32] <= i_wdata;
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_mtip     = (r_mtime >= r_mtimecmp);

endmodule

// File: rtl/intc_irq_source.sv
// intc_irq_source: machine-level interrupt source (MTIP, MSIP, MEIP) for the
// exception unit, accessed as a memory-mapped peripheral.
// Optional build macro: INTC_EDGE_TRIG_EN makes the external gateway rising-edge
// triggered (adds one ext_irq_q flop per source); default is level mode.
// Ports:
//   i_clk, i_rst       clock, synchronous active-low reset
//   i_bus_en/we        access strobe and direction (1 = write)
//   i_bus_addr         byte offset, bits [1:0] ignored
//   i_bus_wdata        write data
//   o_bus_rdata        registered read data
//   o_bus_rvalid       pulses one cycle after a read
//   i_ext_irq          external requests, source id = index + 1
//   o_interrupt        registered OR of active causes
//   o_irq_code         registered highest-priority cause (MEI > MSI > MTI)
module intc_irq_source
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bus_en,
  input  logic             i_bus_we,
  input  logic [4:0]       i_bus_addr,
  input  logic [31:0]      i_bus_wdata,
  output logic [31:0]      o_bus_rdata,
  output logic             o_bus_rvalid,
  input  logic [N_SRC-1:0] i_ext_irq,
  output logic             o_interrupt,
  output logic [3:0]       o_irq_code
);

  logic             w_rd, w_wr;
  logic [4:0]       w_sel;
  logic [63:0]      w_mtime, w_mtimecmp;
  logic             w_mtip, w_meip;
  logic [N_SRC-1:0] w_req, w_set, w_claim_oh, w_cmpl_oh;
  logic [N_SRC-1:0] w_pending_d, w_in_service_d;
  logic [31:0]      w_claim_id, w_rdata;
  logic             w_found;
  cause_e           w_irq_code;

  logic             r_msip;
  logic [N_SRC-1:0] r_enable, r_pending, r_in_service;
  logic [31:0]      r_rdata;
  logic             r_rvalid, r_interrupt;
  cause_e           r_irq_code;

  assign w_rd  = i_bus_en & ~i_bus_we;
  assign w_wr  = i_bus_en & i_bus_we;
  assign w_sel = i_bus_addr & 5'b11100;

  intc_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_cmp_lo  (w_wr && (w_sel == ADDR_MTIMECMP_LO)),
    .i_wr_cmp_hi  (w_wr && (w_sel == ADDR_MTIMECMP_HI)),
    .i_wr_time_lo (w_wr && (w_sel == ADDR_MTIME_LO)),
    .i_wr_time_hi (w_wr && (w_sel == ADDR_MTIME_HI)),
    .i_wdata      (i_bus_wdata),
    .o_mtime      (w_mtime),
    .o_mtimecmp   (w_mtimecmp),
    .o_mtip       (w_mtip)
  );

`ifdef INTC_EDGE_TRIG_EN
  logic [N_SRC-1:0] r_ext_irq_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_ext_irq_q <= '0;
    else        r_ext_irq_q <= i_ext_irq;
  end

  // Edges arriving while the source is in service are dropped.
  assign w_set = i_ext_irq & ~r_ext_irq_q & ~r_in_service;
`else
  assign w_set = i_ext_irq & ~r_in_service;
`endif

  assign w_req  = r_pending & r_enable;
  assign w_meip = |w_req;

  // Claim picks the lowest enabled pending source; complete clears in_service.
  always_comb begin
    w_found    = 1'b0;
    w_claim_id = CLAIM_NONE;
    w_claim_oh = '0;
    w_cmpl_oh  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (w_req[i] && !w_found) begin
        w_found       = 1'b1;
        w_claim_id    = 32'(i + 1);
        w_claim_oh[i] = w_rd && (w_sel == ADDR_CLAIM);
      end
      w_cmpl_oh[i] = w_wr && (w_sel == ADDR_CLAIM) && (i_bus_wdata == 32'(i + 1)) &&
                     r_in_service[i];
    end
  end

  // Claim wins over a simultaneous set, so the source re-arms only after complete.
  assign w_pending_d    = (r_pending | w_set) & ~w_claim_oh;
  assign w_in_service_d = (r_in_service | w_claim_oh) & ~w_cmpl_oh;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      ADDR_MSIP:        w_rdata[0] = r_msip;
      ADDR_MTIMECMP_LO: w_rdata = w_mtimecmp[31:0];
      ADDR_MTIMECMP_HI: w_rdata = w_mtimecmp[63:32];
      ADDR_MTIME_LO:    w_rdata = w_mtime[31:0];
      ADDR_MTIME_HI:    w_rdata = w_mtime[63:32];
      ADDR_EXT_PENDING: w_rdata[N_SRC-1:0] = r_pending;
      ADDR_EXT_ENABLE:  w_rdata[N_SRC-1:0] = r_enable;
      ADDR_CLAIM:       w_rdata = w_claim_id;
      default:          w_rdata = '0;
    endcase
  end

  always_comb begin
    if (w_meip)      w_irq_code = CAUSE_MEI;
    else if (r_msip) w_irq_code = CAUSE_MSI;
    else if (w_mtip) w_irq_code = CAUSE_MTI;
    else             w_irq_code = CAUSE_NONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_msip       <= 1'b0;
      r_enable     <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_interrupt  <= 1'b0;
      r_irq_code   <= CAUSE_NONE;
    end else begin
      if (w_wr && (w_sel == ADDR_MSIP))       r_msip   <= i_bus_wdata[0];
      if (w_wr && (w_sel == ADDR_EXT_ENABLE)) r_enable <= i_bus_wdata[N_SRC-1:0];
      r_pending    <= w_pending_d;
      r_in_service <= w_in_service_d;
      r_rvalid     <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
      r_interrupt  <= w_meip | r_msip | w_mtip;
      r_irq_code   <= w_irq_code;
    end
  end

  assign o_bus_rdata  = r_rdata;
  assign o_bus_rvalid = r_rvalid;
  assign o_interrupt  = r_interrupt;
  assign o_irq_code   = r_irq_code;

endmodule
